// File: rtl/fft_butterfly_scheduler.sv
// Butterfly issue scheduler for an in-place radix-2 DIT FFT over a dual-port sample RAM.
// Issues one butterfly per non-stalled cycle and delays the addresses to form write-back strobes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start
// S_ISSUE | issuing butterflies k = 0..N/2-1 of stage s
// S_DRAIN | waiting PIPE_LAT cycles for the stage's writes to retire
// S_DONE  | one-cycle done pulse
module fft_butterfly_scheduler #(
    parameter int FFT_POINTS  = 256,
    parameter int LOG2_POINTS = 8,
    parameter int PIPE_LAT    = 2,
    localparam int SW = (LOG2_POINTS > 1) ? $clog2(LOG2_POINTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic [SW-1:0]          stage_idx,
    output logic                   rd_en,
    output logic [LOG2_POINTS-1:0] rd_addr_a,
    output logic [LOG2_POINTS-1:0] rd_addr_b,
    output logic [LOG2_POINTS-2:0] tw_addr,
    output logic                   mult_en,
    output logic                   wr_en,
    output logic [LOG2_POINTS-1:0] wr_addr_a,
    output logic [LOG2_POINTS-1:0] wr_addr_b
);
    localparam int L  = LOG2_POINTS;
    localparam int KW = LOG2_POINTS - 1;
    localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(FFT_POINTS / 2 - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(LOG2_POINTS - 1);
    localparam logic [CW-1:0] DRAIN_LD = CW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load;
    logic [L-1:0]  a_next, b_next;
    logic [KW-1:0] tw_next;

    logic          pipe_en [PIPE_LAT];
    logic [L-1:0]  pipe_a  [PIPE_LAT];
    logic [L-1:0]  pipe_b  [PIPE_LAT];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    k_d     = '0;
                    s_d     = '0;
                    load    = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    rd_en = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = S_DRAIN;
                        cnt_d   = DRAIN_LD;
                    end else begin
                        k_d  = k_q + KW'(1);
                        load = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    if (s_q == S_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        s_d     = s_q + SW'(1);
                        k_d     = '0;
                        load    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        mult_en = rd_en;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
    end

    // Address registers hold the pending butterfly so they are valid the cycle it issues.
    always_comb begin
        logic [L-1:0] kk, j, g;
        kk      = L'(k_d);
        j       = kk & ((L'(1) << s_d) - L'(1));
        g       = kk >> s_d;
        a_next  = (g << (int'(s_d) + 1)) | j;
        b_next  = a_next | (L'(1) << s_d);
        tw_next = KW'(j << (L - 1 - int'(s_d)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            s_q       <= '0;
            cnt_q     <= '0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            if (load) begin
                rd_addr_a <= a_next;
                rd_addr_b <= b_next;
                tw_addr   <= tw_next;
            end
        end
    end

    // Delay line shifts through stalls so in-flight writes retire on time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_en[i] <= 1'b0;
                pipe_a[i]  <= '0;
                pipe_b[i]  <= '0;
            end
        end else begin
            pipe_en[0] <= rd_en;
            pipe_a[0]  <= rd_addr_a;
            pipe_b[0]  <= rd_addr_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_en[i] <= pipe_en[i-1];
                pipe_a[i]  <= pipe_a[i-1];
                pipe_b[i]  <= pipe_b[i-1];
            end
        end
    end

    assign stage_idx = s_q;
    assign wr_en     = pipe_en[PIPE_LAT-1];
    assign wr_addr_a = pipe_a[PIPE_LAT-1];
    assign wr_addr_b = pipe_b[PIPE_LAT-1];
endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Scoreboard bench for fft_butterfly_scheduler: an N=8 instance for timing/address tables
// and an N=256 instance for full-length coverage and total latency.
module tb_fft_butterfly_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 1'b0, stall8 = 1'b0;
    logic       busy8, done8, rd_en8, mult_en8, wr_en8;
    logic [1:0] stage8, tw8;
    logic [2:0] ra8, rb8, wa8, wb8;

    logic       start256 = 1'b0, stall256 = 1'b0;
    logic       busy256, done256, rd_en256, mult_en256, wr_en256;
    logic [2:0] stage256;
    logic [6:0] tw256;
    logic [7:0] ra256, rb256, wa256, wb256;

    int checks = 0;
    int failures = 0;

    typedef struct {int due; int a; int b;} wr_t;
    wr_t wq[$];

    int A8[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int B8[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int TW8[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    fft_butterfly_scheduler #(.FFT_POINTS(8), .LOG2_POINTS(3), .PIPE_LAT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .stall(stall8),
        .busy(busy8), .done(done8), .stage_idx(stage8), .rd_en(rd_en8),
        .rd_addr_a(ra8), .rd_addr_b(rb8), .tw_addr(tw8), .mult_en(mult_en8),
        .wr_en(wr_en8), .wr_addr_a(wa8), .wr_addr_b(wb8));

    fft_butterfly_scheduler #(.FFT_POINTS(256), .LOG2_POINTS(8), .PIPE_LAT(2)) dut256 (
        .clk(clk), .rst_n(rst_n), .start(start256), .stall(stall256),
        .busy(busy256), .done(done256), .stage_idx(stage256), .rd_en(rd_en256),
        .rd_addr_a(ra256), .rd_addr_b(rb256), .tw_addr(tw256), .mult_en(mult_en256),
        .wr_en(wr_en256), .wr_addr_a(wa256), .wr_addr_b(wb256));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #1;
        checks++;
        if ({busy8, done8, rd_en8, mult_en8, wr_en8, stage8, ra8, rb8, tw8, wa8, wb8} !== '0) begin
            failures++;
            $display("FAIL reset8_outputs: got %b want all zero",
                     {busy8, done8, rd_en8, mult_en8, wr_en8, stage8, ra8, rb8, tw8, wa8, wb8});
        end
        checks++;
        if ({busy256, done256, rd_en256, mult_en256, wr_en256, stage256, ra256, rb256, tw256, wa256, wb256} !== '0) begin
            failures++;
            $display("FAIL reset256_outputs: got nonzero outputs in reset");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy8, done8, rd_en8, wr_en8} !== 4'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got %b want 0000", {busy8, done8, rd_en8, wr_en8});
        end
    endtask

    // One full N=8 run; cycle 0 is the cycle start is presented.
    task automatic run_n8(input bit stall_case, input bit extra_starts);
        int  last;
        int  n;
        bit  exp_rd;
        wr_t w;
        last = stall_case ? 21 : 19;
        n = 0;
        wq.delete();
        for (int c = 0; c <= last + 3; c++) begin
            @(posedge clk); #1;
            start8 = (c == 0) || (extra_starts && (c == 5 || c == last));
            stall8 = stall_case && (c == 2 || c == 3);
            @(negedge clk);
            if (stall_case)
                exp_rd = (c == 1) || (c >= 4 && c <= 6) || (c >= 9 && c <= 12) || (c >= 15 && c <= 18);
            else
                exp_rd = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16);
            checks++;
            if (rd_en8 !== exp_rd) begin
                failures++;
                $display("FAIL rd_en c=%0d: got %b want %b", c, rd_en8, exp_rd);
            end
            checks++;
            if (mult_en8 !== exp_rd) begin
                failures++;
                $display("FAIL mult_en c=%0d: got %b want %b", c, mult_en8, exp_rd);
            end
            checks++;
            if (busy8 !== (c >= 1 && c <= last)) begin
                failures++;
                $display("FAIL busy c=%0d: got %b want %b", c, busy8, (c >= 1 && c <= last));
            end
            checks++;
            if (done8 !== (c == last)) begin
                failures++;
                $display("FAIL done c=%0d: got %b want %b", c, done8, (c == last));
            end
            if (rd_en8 === 1'b1 && n < 12) begin
                checks++;
                if (ra8 !== 3'(A8[n]) || rb8 !== 3'(B8[n]) || tw8 !== 2'(TW8[n]) || stage8 !== 2'(n / 4)) begin
                    failures++;
                    $display("FAIL rd_addr n=%0d: got a=%0d b=%0d tw=%0d s=%0d want a=%0d b=%0d tw=%0d s=%0d",
                             n, ra8, rb8, tw8, stage8, A8[n], B8[n], TW8[n], n / 4);
                end
                wq.push_back('{c + 2, A8[n], B8[n]});
                n++;
            end
            if (wr_en8 === 1'b1) begin
                checks++;
                if (wq.size() == 0 || wq[0].due != c) begin
                    failures++;
                    $display("FAIL wr_en_unexpected c=%0d: got 1 want 0", c);
                end else begin
                    w = wq.pop_front();
                    if (wa8 !== 3'(w.a) || wb8 !== 3'(w.b)) begin
                        failures++;
                        $display("FAIL wr_addr c=%0d: got (%0d,%0d) want (%0d,%0d)", c, wa8, wb8, w.a, w.b);
                    end
                end
            end else if (wq.size() > 0 && wq[0].due == c) begin
                checks++;
                failures++;
                $display("FAIL wr_en_missing c=%0d: got %b want 1", c, wr_en8);
                void'(wq.pop_front());
            end
        end
        checks++;
        if (n != 12 || wq.size() != 0) begin
            failures++;
            $display("FAIL issue_count: got issued=%0d pending=%0d want issued=12 pending=0", n, wq.size());
        end
        start8 = 1'b0;
        stall8 = 1'b0;
    endtask

    task automatic test_nominal();
        run_n8(1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_n8(1'b0, 1'b1);
    endtask

    task automatic test_stall();
        run_n8(1'b1, 1'b0);
    endtask

    task automatic test_reset_abort();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            start8 = (c == 0);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_en8 !== 1'b1 || busy8 !== 1'b1) begin
            failures++;
            $display("FAIL abort_precondition: got rd_en=%b busy=%b want 1 1", rd_en8, busy8);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, rd_en8, mult_en8, wr_en8, stage8, ra8, rb8, tw8, wa8, wb8} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: got %b want all zero",
                     {busy8, done8, rd_en8, mult_en8, wr_en8, stage8, ra8, rb8, tw8, wa8, wb8});
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                failures++;
                $display("FAIL abort_hold: got done=%b busy=%b want 0 0", done8, busy8);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_n8(1'b0, 1'b0);
    endtask

    task automatic test_n256();
        int  cov [8][256];
        int  n, done_at, bad_addr, bad_mult, sb_err, s, k, j, g, ea, eb, et, bad_cov;
        wr_t w;
        n = 0; done_at = -1; bad_addr = 0; bad_mult = 0; sb_err = 0;
        for (int si = 0; si < 8; si++)
            for (int ai = 0; ai < 256; ai++)
                cov[si][ai] = 0;
        wq.delete();
        for (int c = 0; c <= 1200 && done_at < 0; c++) begin
            @(posedge clk); #1;
            start256 = (c == 0);
            stall256 = 1'b0;
            @(negedge clk);
            if (mult_en256 !== rd_en256) bad_mult++;
            if (rd_en256 === 1'b1) begin
                s = n / 128;
                k = n % 128;
                j = k % (1 << s);
                g = k >> s;
                ea = g * (1 << (s + 1)) + j;
                eb = ea + (1 << s);
                et = j << (7 - s);
                if (ra256 !== 8'(ea) || rb256 !== 8'(eb) || tw256 !== 7'(et) || stage256 !== 3'(s))
                    bad_addr++;
                if (s < 8) begin
                    cov[s][int'(ra256)]++;
                    cov[s][int'(rb256)]++;
                end
                wq.push_back('{c + 2, ea, eb});
                n++;
            end
            if (wr_en256 === 1'b1) begin
                if (wq.size() == 0 || wq[0].due != c) sb_err++;
                else begin
                    w = wq.pop_front();
                    if (wa256 !== 8'(w.a) || wb256 !== 8'(w.b)) sb_err++;
                end
            end else if (wq.size() > 0 && wq[0].due == c) begin
                sb_err++;
                void'(wq.pop_front());
            end
            if (done256 === 1'b1) done_at = c;
        end
        start256 = 1'b0;
        checks++;
        if (done_at != 1041) begin
            failures++;
            $display("FAIL n256_done_latency: got %0d want 1041", done_at);
        end
        checks++;
        if (bad_mult != 0) begin
            failures++;
            $display("FAIL n256_mult_en: got %0d cycles differing from rd_en want 0", bad_mult);
        end
        checks++;
        if (bad_addr != 0 || n != 1024) begin
            failures++;
            $display("FAIL n256_addresses: got bad=%0d issued=%0d want bad=0 issued=1024", bad_addr, n);
        end
        checks++;
        if (sb_err != 0 || wq.size() != 0) begin
            failures++;
            $display("FAIL n256_writeback: got errors=%0d pending=%0d want 0 0", sb_err, wq.size());
        end
        for (int si = 0; si < 8; si++) begin
            bad_cov = 0;
            for (int ai = 0; ai < 256; ai++)
                if (cov[si][ai] != 1) bad_cov++;
            checks++;
            if (bad_cov != 0) begin
                failures++;
                $display("FAIL n256_coverage stage=%0d: got %0d addresses not read exactly once want 0", si, bad_cov);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_nominal();
        test_start_ignored();
        test_stall();
        test_reset_abort();
        test_n256();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
